// File: rtl/input_vc_buffer_pkg.sv
// input_vc_buffer_pkg
//   Shared widths, flit-type codes and framing-FSM state for the router input
//   VC buffer. The flit type lives in the top bits of every flit.
package input_vc_buffer_pkg;

  localparam int DATAW    = 31;  // flit is DATAW+1 bits
  localparam int VCH      = 1;   // VCH+1 virtual channels
  localparam int VCHW     = 0;   // VC index is VCHW+1 bits
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int TYPEW    = 1;   // type field is TYPEW+1 bits
  localparam int FIFO_P1  = 4;   // flits per VC FIFO (= upstream credits)
  localparam int FIFOD_P1 = 2;   // occupancy count is FIFOD_P1+1 bits

  localparam int NVC = VCH + 1;

  typedef logic [DATAW:0] flit_t;
  typedef logic [VCHW:0]  vch_t;
  typedef logic [VCH:0]   vc_vec_t;

  typedef enum logic [TYPEW:0] {
    TYPE_HEAD     = 2'd0,
    TYPE_BODY     = 2'd1,
    TYPE_TAIL     = 2'd2,
    TYPE_HEADTAIL = 2'd3
  } flit_type_e;

  // Input framing: IDLE between packets, BODY while a multi-flit packet is open.
  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BODY = 1'b1
  } vc_state_e;

  function automatic flit_type_e flit_type(input flit_t f);
    return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/input_vc_buffer_if.sv
// input_vc_buffer_if
//   Link-side and allocator-side signals of one router input channel.
//   slave  : the input buffer (receives flits and grants, drives requests,
//            forwarded flits, credits, lock and error status)
//   master : whatever drives it (upstream link + switch allocator, or a bench)
interface input_vc_buffer_if;
  import input_vc_buffer_pkg::*;

  flit_t   idata;   // incoming flit
  logic    ivalid;  // incoming flit valid
  vch_t    ivch;    // VC of incoming flit
  vc_vec_t oreq;    // VC v has a stored flit
  vc_vec_t igrant;  // allocator grant
  flit_t   odata;   // forwarded flit (registered)
  logic    ovalid;  // odata valid
  vch_t    ovch;    // VC of forwarded flit
  vc_vec_t oack;    // one credit pulse per popped flit
  vc_vec_t olck;    // VC v holds an unfinished packet
  vc_vec_t oerr;    // sticky protocol/overflow error

  modport slave (
    input  idata, ivalid, ivch, igrant,
    output oreq, odata, ovalid, ovch, oack, olck, oerr
  );

  modport master (
    output idata, ivalid, ivch, igrant,
    input  oreq, odata, ovalid, ovch, oack, olck, oerr
  );

endinterface

// File: rtl/input_vc_buffer_vc_fifo.sv
// vc_fifo
//   One virtual-channel flit FIFO of DEPTH entries (any DEPTH >= 1, not only
//   powers of two). The caller only asserts push when there is room or a pop
//   happens in the same cycle; pop is only asserted when not empty.
//   clk, rst_ : clock, async active-low reset
//   push/wdata: store wdata at the tail
//   pop       : discard the head; rdata always shows the head
//   full/empty/count : occupancy status, count in 0..DEPTH
module vc_fifo
  import input_vc_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_P1,
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            push,
  input  flit_t           wdata,
  input  logic            pop,
  output flit_t           rdata,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  flit_t           mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count/pointers, so
  // stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// input_vc_buffer
//   Per-physical-channel router input stage. Each arriving flit is stored in
//   the FIFO of its VC; a per-VC framing FSM checks packet structure; the
//   lowest granted non-empty VC is popped each cycle and its flit presented
//   on the registered output together with a one-cycle credit pulse.
//   clk, rst_ : clock, async active-low reset
//   bus       : input_vc_buffer_if.slave (idata/ivalid/ivch/igrant in;
//               oreq/odata/ovalid/ovch/oack/olck/oerr out)
//   ROUTERID, PCHID are identifiers for debug/trace only.
module input_vc_buffer
  import input_vc_buffer_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int DEPTH    = FIFO_P1
) (
  input logic              clk,
  input logic              rst_,
  input_vc_buffer_if.slave bus
);

  localparam int CNTW = $clog2(DEPTH + 1);

  flit_t           rdata      [NVC];
  logic [CNTW-1:0] fifo_count [NVC];
  logic [NVC-1:0]  full, empty;
  logic [NVC-1:0]  push, accept, pop;
  logic [NVC-1:0]  lck_set, lck_clr;
  vch_t            pop_vc;
  logic            pop_any;
  flit_t           pop_data;
  flit_type_e      in_type, pop_type;

  vc_state_e       state_q [NVC];
  logic [NVC-1:0]  lck_q, err_q, oack_q;
  flit_t           odata_q;
  logic            ovalid_q;
  vch_t            ovch_q;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    vc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .push  (accept[v]),
      .wdata (bus.idata),
      .pop   (pop[v]),
      .rdata (rdata[v]),
      .full  (full[v]),
      .empty (empty[v]),
      .count (fifo_count[v])
    );
  end

  assign in_type  = flit_type(bus.idata);
  assign pop_type = flit_type(pop_data);
  assign bus.oreq = ~empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pop      = '0;
    pop_vc   = '0;
    pop_any  = 1'b0;
    pop_data = '0;
    // Fixed priority: lowest VC that is both granted and holding a flit.
    for (int v = 0; v < NVC; v++) begin
      if (!pop_any && bus.igrant[v] && !empty[v]) begin
        pop[v]   = 1'b1;
        pop_vc   = vch_t'(v);
        pop_any  = 1'b1;
        pop_data = rdata[v];
      end
    end
  end

  always_comb begin
    push    = '0;
    accept  = '0;
    lck_set = '0;
    lck_clr = '0;
    for (int v = 0; v < NVC; v++) begin
      push[v]    = bus.ivalid && (bus.ivch == vch_t'(v));
      // A full FIFO still takes the flit when its head leaves this cycle.
      accept[v]  = push[v] && (!full[v] || pop[v]);
      lck_set[v] = accept[v] && (in_type == TYPE_HEAD || in_type == TYPE_HEADTAIL);
      lck_clr[v] = pop[v] && (pop_type == TYPE_TAIL || pop_type == TYPE_HEADTAIL);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) state_q[v] <= VC_IDLE;
      lck_q    <= '0;
      err_q    <= '0;
      oack_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        // Framing only follows flits that were actually stored; an illegal
        // type flags the VC but leaves the state where it was.
        if (accept[v]) begin
          case (state_q[v])
            VC_IDLE: begin
              if (in_type == TYPE_HEAD)               state_q[v] <= VC_BODY;
              else if (in_type != TYPE_HEADTAIL)      err_q[v]   <= 1'b1;
            end
            VC_BODY: begin
              if (in_type == TYPE_TAIL)               state_q[v] <= VC_IDLE;
              else if (in_type != TYPE_BODY)          err_q[v]   <= 1'b1;
            end
            default:                                  state_q[v] <= VC_IDLE;
          endcase
        end
        if (push[v] && !accept[v]) err_q[v] <= 1'b1;  // overflow drop

        // A new packet opening on the same cycle the old one leaves keeps the lock.
        if (lck_set[v])      lck_q[v] <= 1'b1;
        else if (lck_clr[v]) lck_q[v] <= 1'b0;
      end

      odata_q  <= pop_data;
      ovch_q   <= pop_vc;
      ovalid_q <= pop_any;
      oack_q   <= pop;
    end
  end

  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ovch   = ovch_q;
  assign bus.oack   = oack_q;
  assign bus.olck   = lck_q;
  assign bus.oerr   = err_q;

  // Trace-only identifiers and occupancy counts have no functional load.
  logic unused_dbg;
  always_comb begin
    unused_dbg = ^{ROUTERID, PCHID};
    for (int v = 0; v < NVC; v++) unused_dbg = unused_dbg ^ (^fifo_count[v]);
  end

endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Per-physical-channel input stage of a router: sits directly downstream of the upstream router's output channel, on the far end of the link. Stores arriving flits in one FIFO per virtual channel. Presents head-of-line flits to the switch allocator and returns one credit (ack) per flit forwarded. Reports per-VC packet lock status back upstream.

## Interface
Parameters:
- ROUTERID, 0, router identifier (debug/trace only)
- PCHID, 0, physical channel identifier (debug/trace only)
- DEPTH, `FIFO_P1, flits per VC FIFO; equals the upstream credit count

Ports:
- clk  in  1  clock
- rst_  in  1  reset; one clock, reset asynchronous and active-low
- idata  in  `DATAW+1  incoming flit; type field at [`TYPE_MSB:`TYPE_LSB]
- ivalid  in  1  flit valid this cycle
- ivch  in  `VCHW+1  VC of incoming flit
- oreq  out  `VCH+1  VC v has a stored flit
- igrant  in  `VCH+1  allocator grant, expected one-hot
- odata  out  `DATAW+1  forwarded flit, registered
- ovalid  out  1  odata valid
- ovch  out  `VCHW+1  VC of forwarded flit
- oack  out  `VCH+1  one-cycle credit pulse per flit popped from VC v; to upstream iack
- olck  out  `VCH+1  VC v holds an unfinished packet; to upstream ilck
- oerr  out  `VCH+1  sticky protocol/overflow error per VC

## Operation
- Write: when ivalid, push idata into FIFO[ivch]. If that FIFO is full, drop the flit and set oerr[ivch]; the count does not change.
- Per-VC input-framing FSM with two states:
  - IDLE: HEAD goes to BODY; HEADTAIL stays in IDLE.
  - BODY: BODY stays in BODY; TAIL goes to IDLE.
  - Any other type in either state sets oerr[v]. The flit is still stored and the state is unchanged.
- oreq[v] = FIFO[v] not empty. It is derived from stored entries only; there is no bypass of an empty FIFO.
- Pop: the served VC is the lowest v with igrant[v] & oreq[v]. All other grant bits are ignored.
  - A grant to an empty VC is a no-op.
  - At most one pop per cycle.
- The popped flit appears on odata/ovch with ovalid=1 on the next cycle. oack[v] pulses on that same next cycle.
- If no pop occurs, odata, ovch and ovalid return to 0 on the next cycle.
- Lock:
  - olck[v] sets on the cycle after a HEAD or HEADTAIL is written.
  - It clears on the cycle after a TAIL or HEADTAIL is popped.
  - If a set and a clear coincide on the same VC, set wins.
- Simultaneous push and pop on the same VC: occupancy is unchanged and FIFO order is preserved. A push to a full FIFO with a same-cycle pop is accepted.
- Occupancy count is `FIFOD_P1+1 bits and ranges 0..DEPTH. Pointers wrap modulo DEPTH. DEPTH need not be a power of two.

## Timing
- Reset (async assert, value held until deassert): odata=0, ovalid=0, ovch=0, oack=0, olck=0, oerr=0.
  - All FIFOs empty and all FSMs IDLE, so oreq=0.
  - Stored flits are discarded.
- Pop to output latency: 1 cycle. Push to oreq visible: 1 cycle, so minimum ivalid-to-ovalid is 2 cycles.
- oreq is combinational from registered state. igrant is sampled at the same clock edge.
- oack is registered: exactly one pulse per popped flit, and never a pulse for a dropped flit.
- oerr is cleared only by reset.

## Structure
- The shared header define.h holds `DATAW, `VCH, `VCHW, `TYPE_MSB/`TYPE_LSB, `TYPEW, `FIFO_P1, `FIFOD_P1, and the flit-type codes `TYPE_HEAD, `TYPE_BODY, `TYPE_TAIL, `TYPE_HEADTAIL.
- One sub-module, vc_fifo (DEPTH entries, push/pop/full/empty/count), instanced per VC with a generate loop.
- The framing FSM, lock, arbitration pick and output register stay in the top level.

## Test plan
- Reset mid-traffic: drop rst_ between clock edges -> all outputs 0 immediately; oreq=0 after release.
- 4-flit packet on VC0 (HEAD, BODY, BODY, TAIL), igrant=1 held -> flits come out in order, one cycle after each pop.
  - oack[0] pulses exactly 4 times.
  - olck[0]=1 from the cycle after the HEAD write through the cycle after the TAIL pop, then 0.
- DEPTH=4, write 5 flits to VC0 with igrant=0 -> count=4, 5th flit dropped, oerr[0]=1, no oack.
- VC0 holding 2 flits, push and grant in the same cycle for 3 cycles -> count stays 2, output order matches push order.
- Both VCs non-empty, igrant=2'b11 -> only VC0 pops; ovch=0; oack=2'b01.
- BODY arriving on an IDLE VC1 -> oerr[1]=1, flit stored, FSM stays IDLE; a subsequent HEADTAIL pulses olck[1] set then clear after its pop.
